// File: rtl/hwag.sv
// Crank angle generator for a 60-2 trigger wheel: filters the VR input, finds the gap,
// interpolates 64 ticks per tooth and drives one ignition coil from an angle window.
module hwag #(
    parameter int unsigned FILTER     = 3,
    parameter int unsigned CAP_MIN    = 128,
    parameter int unsigned CAP_MAX    = 65535,
    parameter int unsigned TOOTH_LAST = 57,
    parameter int unsigned SYNC_TEETH = 4,
    parameter int unsigned GAP_RATIO  = 2,
    parameter int unsigned ANGLE_TOP  = 3839,
    parameter int unsigned IGN_ANGLE  = 3830,
    parameter int unsigned IGN_CHARGE = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic cap_in,
    output logic cap_out,
    output logic led1_out,
    output logic led2_out,
    output logic coil14_out
);

    localparam int unsigned FW = $clog2(FILTER + 1);
    localparam int unsigned VW = $clog2(SYNC_TEETH + 1);

    localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER - 1);
    localparam logic [VW-1:0] VALID_FULL = VW'(SYNC_TEETH);
    localparam logic [15:0]   PER_MIN    = 16'(CAP_MIN);
    localparam logic [15:0]   PER_MAX    = 16'(CAP_MAX);
    localparam logic [5:0]    TOOTH_END  = 6'(TOOTH_LAST);
    localparam logic [11:0]   ANG_TOP    = 12'(ANGLE_TOP);
    localparam logic [11:0]   WIN_ON     =
        12'((IGN_ANGLE + ANGLE_TOP + 1 - IGN_CHARGE) % (ANGLE_TOP + 1));
    localparam logic [11:0]   WIN_OFF    = 12'(IGN_ANGLE);

    typedef enum logic [0:0] {StHunt, StSynced} state_e;

    logic          sync1_q, sync2_q, cap_q;
    logic [FW-1:0] filt_cnt_q;
    logic [15:0]   per_cnt_q, cur_per_q, prev_per_q;
    logic          last_gap_q;
    state_e        state_q;
    logic [VW-1:0] valid_q;
    logic [5:0]    tooth_q;
    logic [11:0]   angle_q;
    logic [15:0]   div_q;
    logic          led1_q, led2_q, coil_q;

    logic          cap_rise, stall, legal_ev, gap, tick_exp, in_win;
    logic [17:0]   gap_lim;
    logic [15:0]   tick_base, tick_len;
    logic [11:0]   ang_lim;

    // Synchronizer plus run-length filter: a level must persist FILTER samples to pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            cap_q      <= 1'b0;
            filt_cnt_q <= '0;
        end else begin
            sync1_q <= cap_in;
            sync2_q <= sync1_q;
            if (sync2_q == cap_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                cap_q      <= sync2_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FW'(1);
            end
        end
    end

    assign cap_rise = sync2_q && !cap_q && (filt_cnt_q == FILT_LAST);

    always_comb begin
        stall    = (per_cnt_q == PER_MAX);
        legal_ev = cap_rise && (per_cnt_q >= PER_MIN);
        gap_lim  = 18'(GAP_RATIO) * {2'b00, cur_per_q};
        gap      = ({2'b00, per_cnt_q} > gap_lim);
        // After the gap tooth, interpolate with the last normal tooth instead.
        tick_base = last_gap_q ? prev_per_q : cur_per_q;
        tick_len  = tick_base >> 6;
        if (tick_len == 16'd0) begin
            tick_len = 16'd1;
        end
        tick_exp = (div_q >= tick_len - 16'd1);
        ang_lim  = (tooth_q == TOOTH_END) ? ANG_TOP : {tooth_q, 6'h3f};
        if (WIN_ON < WIN_OFF) begin
            in_win = (angle_q >= WIN_ON) && (angle_q < WIN_OFF);
        end else begin
            in_win = (angle_q >= WIN_ON) || (angle_q < WIN_OFF);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_cnt_q  <= 16'd0;
            cur_per_q  <= 16'd0;
            prev_per_q <= 16'd0;
            last_gap_q <= 1'b0;
        end else if (legal_ev) begin
            per_cnt_q  <= 16'd1;
            prev_per_q <= cur_per_q;
            cur_per_q  <= per_cnt_q;
            last_gap_q <= gap;
        end else if (!stall) begin
            per_cnt_q <= per_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StHunt;
            valid_q <= '0;
            tooth_q <= 6'd0;
            angle_q <= 12'd0;
            div_q   <= 16'd0;
            led1_q  <= 1'b0;
            led2_q  <= 1'b0;
            coil_q  <= 1'b0;
        end else begin
            led1_q <= (state_q == StSynced);
            coil_q <= (state_q == StSynced) && in_win;
            div_q  <= tick_exp ? 16'd0 : div_q + 16'd1;
            if (stall) begin
                state_q <= StHunt;
                valid_q <= '0;
                coil_q  <= 1'b0;
            end else if (legal_ev) begin
                div_q <= 16'd0;
                unique case (state_q)
                    StHunt: begin
                        if (gap && (valid_q == VALID_FULL)) begin
                            state_q <= StSynced;
                            tooth_q <= 6'd0;
                            angle_q <= 12'd0;
                            led2_q  <= ~led2_q;
                        end else if (valid_q != VALID_FULL) begin
                            valid_q <= valid_q + VW'(1);
                        end
                    end
                    StSynced: begin
                        if ((tooth_q == TOOTH_END) && gap) begin
                            tooth_q <= 6'd0;
                            angle_q <= 12'd0;
                            led2_q  <= ~led2_q;
                        end else if ((tooth_q != TOOTH_END) && !gap) begin
                            tooth_q <= tooth_q + 6'd1;
                            angle_q <= {tooth_q + 6'd1, 6'd0};
                        end else begin
                            state_q <= StHunt;
                            valid_q <= '0;
                            coil_q  <= 1'b0;
                        end
                    end
                    default: state_q <= StHunt;
                endcase
            end else if ((state_q == StSynced) && tick_exp && (angle_q < ang_lim)) begin
                angle_q <= angle_q + 12'd1;
            end
        end
    end

    assign cap_out    = cap_q;
    assign led1_out   = led1_q;
    assign led2_out   = led2_q;
    assign coil14_out = coil_q;

endmodule

// File: tb/tb_hwag.sv
// Directed bench for hwag: filter pulses, gap sync, angle interpolation, coil window, faults.
module tb_hwag;

    localparam int CAP_MAX_TB = 8191;

    logic clk, rst, cap_in;
    logic cap_out, led1_out, led2_out, coil14_out;

    int tests = 0;
    int fails = 0;

    hwag #(.CAP_MAX(CAP_MAX_TB)) dut (
        .clk        (clk),
        .rst        (rst),
        .cap_in     (cap_in),
        .cap_out    (cap_out),
        .led1_out   (led1_out),
        .led2_out   (led2_out),
        .coil14_out (coil14_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", tests, fails);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int angle();
        return int'(dut.angle_q);
    endfunction

    // One tooth: rising edge now, high for 128 clk, next edge after per clk.
    task automatic drive(input int per, input int exp_before, input int exp_at);
        bit seen;
        int last_ang;
        seen     = 1'b0;
        last_ang = angle();
        cap_in   = 1'b1;
        for (int i = 0; i < per; i++) begin
            if (i == 128) cap_in = 1'b0;
            @(negedge clk);
            if (!seen && cap_out) begin
                seen = 1'b1;
                if (exp_before >= 0) check("angle_before_edge", last_ang, exp_before);
                if (exp_at >= 0) check("angle_at_edge", angle(), exp_at);
            end
            last_ang = angle();
        end
        check("tooth_event_seen", int'(seen), 1);
    endtask

    // After losing sync on an edge: four teeth, then a gap, then the tooth-0 edge.
    task automatic resync();
        repeat (3) drive(256, -1, -1);
        drive(768, -1, -1);
        check("led1_before_resync", int'(led1_out), 0);
        drive(256, -1, 0);
        check("led1_after_resync", int'(led1_out), 1);
    endtask

    // Coil monitor for one revolution.
    bit coil_mon = 1'b0;
    bit coil_on_seen = 1'b0;
    bit coil_off_seen = 1'b0;
    int coil_hi = 0;
    int coil_on_ang = -1;
    int coil_off_ang = -1;

    always @(negedge clk) begin
        if (coil_mon) begin
            if (coil14_out) begin
                coil_hi++;
                if (!coil_on_seen) begin
                    coil_on_seen = 1'b1;
                    coil_on_ang  = angle();
                end
            end else if (coil_on_seen && !coil_off_seen) begin
                coil_off_seen = 1'b1;
                coil_off_ang  = angle();
            end
        end
    end

    typedef struct {
        int width;
        int follow;
    } pulse_t;

    pulse_t pv [4];

    initial begin
        bit rose, seen, dropped;
        int lat, n;

        pv[0] = '{1, 0};
        pv[1] = '{2, 0};
        pv[2] = '{3, 1};
        pv[3] = '{10, 1};

        rst    = 1'b0;
        cap_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cap_in = ~cap_in;
        end
        check("rst_cap_out", int'(cap_out), 0);
        check("rst_led1", int'(led1_out), 0);
        check("rst_led2", int'(led2_out), 0);
        check("rst_coil", int'(coil14_out), 0);
        cap_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_led1", int'(led1_out), 0);
        check("post_rst_cap_out", int'(cap_out), 0);

        // Filter pulse table
        for (int k = 0; k < 4; k++) begin
            repeat (20) @(negedge clk);
            rose   = 1'b0;
            lat    = 0;
            cap_in = 1'b1;
            for (int i = 0; i < 14; i++) begin
                if (i == pv[k].width) cap_in = 1'b0;
                @(negedge clk);
                if (cap_out && !rose) begin
                    rose = 1'b1;
                    lat  = i + 1;
                end
            end
            check($sformatf("pulse_w%0d_follow", pv[k].width), int'(rose), pv[k].follow);
            if (pv[k].follow != 0) begin
                check($sformatf("pulse_w%0d_latency_3to5", pv[k].width),
                      int'(lat >= 3 && lat <= 5), 1);
            end
        end
        repeat (200) @(negedge clk);
        check("pulses_no_sync", int'(led1_out), 0);

        // Hunt from mid-wheel (tooth 50), sync on the gap
        for (int t = 50; t < 57; t++) drive(256, -1, -1);
        check("led1_hunting", int'(led1_out), 0);
        drive(768, -1, -1);
        check("led1_before_gap", int'(led1_out), 0);
        coil_mon = 1'b1;
        drive(256, -1, 0);
        check("led1_synced", int'(led1_out), 1);
        check("led2_first_sync", int'(led2_out), 1);

        // Full revolution with angle snaps and ceilings
        for (int t = 1; t < 57; t++) drive(256, (t - 1) * 64 + 63, t * 64);
        drive(768, 56 * 64 + 63, 57 * 64);
        drive(256, 3839, 0);
        coil_mon = 1'b0;
        check("led2_after_wrap", int'(led2_out), 0);
        check("led1_after_wrap", int'(led1_out), 1);
        check("coil_on_angle", coil_on_ang, 2806);
        check("coil_off_angle", coil_off_ang, 3830);
        check("coil_high_cycles", coil_hi, 1024 * 4);
        check("coil_low_after_wrap", int'(coil14_out), 0);

        // Gap at tooth 20
        for (int t = 1; t < 19; t++) drive(256, -1, -1);
        drive(768, -1, -1);
        drive(256, -1, -1);
        check("fault_gap_led1", int'(led1_out), 0);
        check("fault_gap_coil", int'(coil14_out), 0);
        resync();
        check("led2_fault_resync", int'(led2_out), 1);

        // Stall at tooth 50 while the coil is charging
        for (int t = 1; t < 50; t++) drive(256, -1, -1);
        cap_in = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = cap_out;
        end
        check("stall_tooth_event", int'(seen), 1);
        dropped = 1'b0;
        n       = 0;
        for (int i = 1; i <= CAP_MAX_TB + 64 && !dropped; i++) begin
            if (i == 124) cap_in = 1'b0;
            @(negedge clk);
            if (i == 1000) begin
                check("stall_angle_ceiling", angle(), 50 * 64 + 63);
                check("stall_coil_charging", int'(coil14_out), 1);
            end
            if (!led1_out) begin
                dropped = 1'b1;
                n       = i;
            end
        end
        check("stall_led1_dropped", int'(dropped), 1);
        check("stall_time_window", int'(n >= CAP_MAX_TB - 2 && n <= CAP_MAX_TB + 3), 1);
        check("stall_coil_off", int'(coil14_out), 0);
        drive(256, -1, -1);
        check("stall_first_edge_led1", int'(led1_out), 0);
        resync();
        check("led2_stall_resync", int'(led2_out), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
